// File: rtl/lcd_pixel_sink_if.sv
// lcd_pixel_sink_if: framebuffer write port; master drives valid/addr/data, slave returns ready.
interface lcd_pixel_sink_if;
    logic        fb_wr_valid;
    logic [14:0] fb_wr_addr;
    logic [1:0]  fb_wr_data;
    logic        fb_wr_ready;
    modport master (output fb_wr_valid, output fb_wr_addr, output fb_wr_data, input fb_wr_ready);
    modport slave  (input fb_wr_valid, input fb_wr_addr, input fb_wr_data, output fb_wr_ready);
endinterface

// File: rtl/lcd_pixel_sink.sv
// lcd_pixel_sink: palette-maps draw-mode pixels and queues {address, shade} writes to the framebuffer.
module lcd_pixel_sink (
    input  logic             clock,
    input  logic             nreset,
    input  logic [1:0]       mode_n,
    input  logic [7:0]       y_pos,
    input  logic             pixel_valid,
    input  logic [1:0]       pixel_data,
    input  logic [1:0]       palette,
    input  logic [7:0]       bgp,
    input  logic [7:0]       obp0,
    input  logic [7:0]       obp1,
    lcd_pixel_sink_if.master fb,
    output logic             overflow,
    output logic             line_overrun,
    output logic             frame_done
);
    logic [1:0]  prev_mode;
    logic [7:0]  column, line, col_eff, line_eff, pal_reg;
    logic [16:0] mem [8];
    logic [2:0]  wr_ptr, rd_ptr;
    logic [3:0]  count;
    logic        frame_pending, entry, pop, want, push, full_drop, frame_end, bad_pixel;
    logic [1:0]  shade;
    logic [14:0] addr;
    // A pixel on the draw-entry cycle already sees the cleared column and freshly latched line.
    always_comb begin
        entry = mode_n == 2'd3 && prev_mode != 2'd3;
        col_eff = entry ? 8'd0 : column;
        line_eff = entry ? y_pos : line;
        pal_reg = palette == 2'b01 ? obp0 : palette == 2'b10 ? obp1 : bgp;
        shade = pal_reg[{pixel_data, 1'b0} +: 2];
        addr = 15'({line_eff, 7'd0}) + 15'({line_eff, 5'd0}) + 15'(col_eff);
        pop = fb.fb_wr_valid && fb.fb_wr_ready;
        bad_pixel = pixel_valid && (mode_n != 2'd3 || col_eff >= 8'd160);
        want = pixel_valid && !bad_pixel;
        push = want && (count != 4'd8 || pop);
        full_drop = want && !push;
        frame_end = prev_mode == 2'd3 && mode_n == 2'd0 && line == 8'd143;
    end
    assign fb.fb_wr_valid = count != 4'd0 && !nreset;
    assign fb.fb_wr_addr = fb.fb_wr_valid ? mem[rd_ptr][16:2] : '0;
    assign fb.fb_wr_data = fb.fb_wr_valid ? mem[rd_ptr][1:0] : '0;
    assign frame_done = frame_pending && count == 4'd0 && !nreset;
    always_ff @(posedge clock) begin
        if (nreset) begin
            prev_mode <= '0;
            column <= '0;
            line <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            frame_pending <= 1'b0;
            overflow <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            prev_mode <= mode_n;
            column <= push ? col_eff + 8'd1 : col_eff;
            line <= line_eff;
            wr_ptr <= wr_ptr + 3'(push);
            rd_ptr <= rd_ptr + 3'(pop);
            count <= count + 4'(push) - 4'(pop);
            frame_pending <= frame_end || (frame_pending && !frame_done);
            overflow <= overflow || full_drop;
            line_overrun <= line_overrun || bad_pixel;
        end
    end
    always_ff @(posedge clock) if (push) mem[wr_ptr] <= {addr, shade};
endmodule

// File: tb/tb_lcd_pixel_sink.sv
// tb_lcd_pixel_sink: directed tables and sequences plus random traffic against a queue-based reference model.
module tb_lcd_pixel_sink;
    logic       clock = 1'b0;
    logic       nreset = 1'b1;
    logic [1:0] mode_n = '0;
    logic [7:0] y_pos = '0;
    logic       pixel_valid = 1'b0;
    logic [1:0] pixel_data = '0;
    logic [1:0] palette = '0;
    logic [7:0] bgp = '0, obp0 = '0, obp1 = '0;
    logic       overflow, line_overrun, frame_done;
    lcd_pixel_sink_if fb ();

    lcd_pixel_sink dut (
        .clock(clock), .nreset(nreset), .mode_n(mode_n), .y_pos(y_pos),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data), .palette(palette),
        .bgp(bgp), .obp0(obp0), .obp1(obp1), .fb(fb.master),
        .overflow(overflow), .line_overrun(line_overrun), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0, done_cnt = 0;
    logic [16:0] wlog[$];
    always @(posedge clock) begin
        if (fb.fb_wr_valid && fb.fb_wr_ready) wlog.push_back({fb.fb_wr_addr, fb.fb_wr_data});
        if (frame_done) done_cnt++;
    end

    // Reference model: pending writes as a queue of {address, shade}
    logic [16:0] mq[$];
    int m_prev = 0, m_col = 0, m_line = 0;
    bit m_ovf = 0, m_lor = 0, m_pend = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop, done;
        int col, ln;
        logic [7:0] pr;
        logic [1:0] sh;
        if (nreset) begin
            mq.delete();
            m_prev = 0; m_col = 0; m_line = 0; m_ovf = 0; m_lor = 0; m_pend = 0;
            return;
        end
        pop = mq.size() != 0 && fb.fb_wr_ready;
        done = m_pend && mq.size() == 0;
        col = (mode_n == 3 && m_prev != 3) ? 0 : m_col;
        ln = (mode_n == 3 && m_prev != 3) ? int'(y_pos) : m_line;
        if (m_prev == 3 && mode_n == 0 && m_line == 143) m_pend = 1;
        else if (done) m_pend = 0;
        if (pop) void'(mq.pop_front());
        if (pixel_valid) begin
            if (mode_n != 3 || col >= 160) m_lor = 1;
            else if (mq.size() >= 8) m_ovf = 1;
            else begin
                pr = palette == 1 ? obp0 : palette == 2 ? obp1 : bgp;
                sh = 2'((pr >> (2 * int'(pixel_data))) & 8'd3);
                mq.push_back({15'(ln * 160 + col), sh});
                col++;
            end
        end
        m_col = col; m_line = ln; m_prev = int'(mode_n);
    endtask

    task automatic compare();
        bit v;
        v = mq.size() != 0 && !nreset;
        check("valid", fb.fb_wr_valid, v);
        if (v) begin
            check("addr", fb.fb_wr_addr, mq[0][16:2]);
            check("data", fb.fb_wr_data, mq[0][1:0]);
        end
        check("overflow", overflow, m_ovf);
        check("line_overrun", line_overrun, m_lor);
        check("frame_done", frame_done, m_pend && mq.size() == 0 && !nreset);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic enter_line(input logic [7:0] y);
        pixel_valid = 1'b0; mode_n = 2'd2; y_pos = y;
        tick();
        mode_n = 2'd3;
        tick();
    endtask

    task automatic pix(input logic [1:0] d);
        pixel_valid = 1'b1; pixel_data = d;
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b1; pixel_valid = 1'b0; mode_n = 2'd0;
        tick();
        nreset = 1'b0;
    endtask

    typedef struct {logic [1:0] pal; logic [7:0] b, o0, o1; logic [1:0] d, exp;} vec_t;
    vec_t vt[8];

    initial begin
        int bad, d0;
        vt[0] = '{2'd2, 8'h00, 8'h00, 8'h1B, 2'd0, 2'd3};
        vt[1] = '{2'd3, 8'h00, 8'hFF, 8'hFF, 2'd2, 2'd0};
        vt[2] = '{2'd0, 8'hE4, 8'h00, 8'h00, 2'd2, 2'd2};
        vt[3] = '{2'd1, 8'h00, 8'h1B, 8'h00, 2'd1, 2'd2};
        vt[4] = '{2'd2, 8'h00, 8'h00, 8'hE4, 2'd3, 2'd3};
        vt[5] = '{2'd0, 8'h1B, 8'h00, 8'h00, 2'd3, 2'd0};
        vt[6] = '{2'd3, 8'hE4, 8'h00, 8'h00, 2'd1, 2'd1};
        vt[7] = '{2'd1, 8'hFF, 8'h93, 8'hFF, 2'd2, 2'd1};
        fb.fb_wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", fb.fb_wr_valid, 0);
        check("rst_addr", fb.fb_wr_addr, 0);
        check("rst_flags", {overflow, line_overrun, frame_done}, 0);
        nreset = 1'b0;

        // Full line at y=5 through bgp=E4
        bgp = 8'hE4; palette = 2'd0;
        enter_line(8'd5);
        wlog.delete();
        for (int i = 0; i < 160; i++) begin
            pixel_valid = 1'b1; pixel_data = 2'(i % 4);
            tick();
            if (i == 0) begin
                check("first_valid", fb.fb_wr_valid, 1);
                check("first_addr", fb.fb_wr_addr, 800);
                check("first_data", fb.fb_wr_data, 0);
            end
        end
        pixel_valid = 1'b0;
        repeat (2) tick();
        check("line_writes", wlog.size(), 160);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] !== {15'(800 + i), 2'(i % 4)}) bad++;
        check("line_sequence", bad, 0);

        // Palette mapping table
        enter_line(8'd10);
        foreach (vt[i]) begin
            palette = vt[i].pal; bgp = vt[i].b; obp0 = vt[i].o0; obp1 = vt[i].o1;
            pix(vt[i].d);
            check($sformatf("pal_vec%0d_data", i), fb.fb_wr_data, vt[i].exp);
            check($sformatf("pal_vec%0d_addr", i), fb.fb_wr_addr, 1600 + i);
            bgp = ~bgp; obp0 = ~obp0; obp1 = ~obp1;
            tick();
        end

        // 161 pixels on one line
        palette = 2'd0; bgp = 8'hE4;
        enter_line(8'd30);
        wlog.delete();
        for (int i = 0; i < 160; i++) pix(2'(i % 4));
        check("lor_before", line_overrun, 0);
        pix(2'd1);
        repeat (2) tick();
        check("lor_after", line_overrun, 1);
        check("overrun_writes", wlog.size(), 160);
        bad = 0;
        foreach (wlog[i]) if (wlog[i][16:2] == 15'd4960) bad++;
        check("no_col160", bad, 0);

        // FIFO full with ready low
        do_reset();
        fb.fb_wr_ready = 1'b0;
        enter_line(8'd20);
        wlog.delete();
        for (int i = 0; i < 9; i++) begin
            pix(2'(i % 4));
            check("held_addr", fb.fb_wr_addr, 3200);
            check("ovf_progress", overflow, i == 8);
        end
        fb.fb_wr_ready = 1'b1;
        repeat (9) tick();
        check("drain_writes", wlog.size(), 8);
        bad = 0;
        foreach (wlog[i]) if (wlog[i][16:2] !== 15'(3200 + i)) bad++;
        check("drain_order", bad, 0);
        pix(2'd0);
        check("col_after_drop", fb.fb_wr_addr, 3208);
        tick();

        // End of frame with queued writes and toggling ready
        do_reset();
        fb.fb_wr_ready = 1'b0;
        enter_line(8'd143);
        for (int i = 0; i < 4; i++) pix(2'(i));
        mode_n = 2'd0;
        tick();
        wlog.delete();
        d0 = done_cnt;
        for (int i = 0; i < 20; i++) begin
            fb.fb_wr_ready = i[0];
            tick();
            if (frame_done) check("done_after_writes", wlog.size(), 4);
        end
        check("done_pulses", done_cnt - d0, 1);

        // Reset with queued writes and a pending frame
        fb.fb_wr_ready = 1'b0;
        enter_line(8'd143);
        for (int i = 0; i < 5; i++) pix(2'(i % 4));
        mode_n = 2'd0;
        tick();
        nreset = 1'b1;
        tick();
        check("rst_mid_valid", fb.fb_wr_valid, 0);
        nreset = 1'b0; fb.fb_wr_ready = 1'b1;
        d0 = done_cnt;
        wlog.delete();
        repeat (10) tick();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_writes", wlog.size(), 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, mode_n == 2'd3 ? 299 : 39) == 0) begin
                mode_n = 2'($urandom_range(0, 3));
                y_pos = $urandom_range(0, 3) == 0 ? 8'd143 : 8'($urandom_range(0, 143));
            end
            if ($urandom_range(0, 19) == 0) y_pos = 8'($urandom_range(0, 143));
            pixel_valid = mode_n == 2'd3 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 30) == 0;
            pixel_data = 2'($urandom);
            palette = 2'($urandom);
            bgp = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
            fb.fb_wr_ready = $urandom_range(0, 2) != 0;
            nreset = $urandom_range(0, 499) == 0;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_pixel_sink.md
LCD_PIXEL_SINK -- requirements
Module: lcd_pixel_sink

Interface
REQ-001 SHALL have port: clock  input  1  system dot clock; all state updates on rising edge.
REQ-002 SHALL have port: nreset  input  1  reset, synchronous, active-high (reset asserted while nreset==1).
REQ-003 SHALL have port: mode_n  input  2  current LCD mode from the LCD mode FSM (0 HBlank, 1 VBlank, 2 OAM, 3 draw).
REQ-004 SHALL have port: y_pos  input  8  current line number from the LCD mode FSM.
REQ-005 SHALL have port: pixel_valid  input  1  one pixel offered this cycle; no backpressure.
REQ-006 SHALL have port: pixel_data  input  2  raw 2-bit colour index.
REQ-007 SHALL have port: palette  input  2  palette select: 00 BGP, 01 OBP0, 10 OBP1, 11 treated as BGP.
REQ-008 SHALL have ports: bgp, obp0, obp1  input  8 each  palette registers; shade for index d = reg[2d+1:2d].
REQ-009 SHALL have port: fb_wr_valid  output  1  framebuffer write request.
REQ-010 SHALL have port: fb_wr_addr  output  15  framebuffer address = line*160 + column.
REQ-011 SHALL have port: fb_wr_data  output  2  mapped shade.
REQ-012 SHALL have port: fb_wr_ready  input  1  framebuffer accepts the write when high with fb_wr_valid.
REQ-013 SHALL have ports: overflow, line_overrun  output  1 each  sticky error flags.
REQ-014 SHALL have port: frame_done  output  1  single-cycle end-of-frame pulse.

Function
REQ-015 SHALL map each pixel through the selected palette using palette values sampled in the cycle pixel_valid is high.
REQ-016 SHALL keep an internal column counter (8 bit); cleared on the cycle mode_n changes from any value to 3; incremented per accepted pixel.
REQ-017 SHALL latch y_pos into an internal line register on the same 3-entry edge; address uses the latched line, not the live y_pos.
REQ-018 SHALL drop pixels arriving with column >= 160 (no write, counter saturates at 160) and set line_overrun.
REQ-019 SHALL drop pixels with pixel_valid high while mode_n != 3, and set line_overrun.
REQ-020 SHALL buffer {address, shade} in an 8-entry FIFO between input and framebuffer port.
REQ-021 SHALL present FIFO head as fb_wr_valid/addr/data; a pixel entering an empty FIFO at cycle N appears at cycle N+1 (registered output).
REQ-022 SHALL hold fb_wr_addr/fb_wr_data stable while fb_wr_valid=1 and fb_wr_ready=0; pop only on valid&&ready.
REQ-023 SHALL, on push with FIFO full and no pop same cycle, drop the pixel, set overflow, and not advance the column counter.
REQ-024 SHALL accept a push when FIFO full and a pop occurs in the same cycle (count unchanged).
REQ-025 SHALL set an internal frame_pending flag on the cycle mode_n changes 3->0 while latched line == 143.
REQ-026 SHALL pulse frame_done for exactly one cycle on the first cycle frame_pending=1, FIFO empty, fb_wr_valid=0; then clear frame_pending.
REQ-027 SHALL keep overflow and line_overrun set until reset; they never clear otherwise.
REQ-028 SHALL use modulo-free address arithmetic: max address 143*160+159 = 23039 fits 15 bits.

Reset
REQ-029 SHALL, while nreset==1, force: fb_wr_valid 0, fb_wr_addr 0, fb_wr_data 0, overflow 0, line_overrun 0, frame_done 0, FIFO empty, column 0, line 0, frame_pending 0.
REQ-030 SHALL discard FIFO contents and any pending frame_done when reset asserts mid-line; first cycle after release behaves as post-reset idle.

Verification
REQ-031 SHALL cover: mode 3 entry at y_pos=5, bgp=0xE4, 160 pixels index 0..3 repeating, ready=1 -> 160 writes, addr 800..959, shades 0,1,2,3 repeating, first write one cycle after first pixel.
REQ-032 SHALL cover: obp1=0x1B, palette=10, pixel_data=0 -> fb_wr_data=3; palette=11, bgp=0x00 -> fb_wr_data=0.
REQ-033 SHALL cover: ready=0, 9 pixels pushed -> 8 held, 9th dropped, overflow=1, fb_wr_addr stable; ready=1 -> 8 writes in order, columns 0..7.
REQ-034 SHALL cover: 161 pixels in one line -> 160 writes, line_overrun=1, no write to column 160.
REQ-035 SHALL cover: line 143 draw ends (3->0) with 4 entries queued, ready toggling -> frame_done one cycle only after last write, never before.
REQ-036 SHALL cover: reset asserted with 5 entries queued and frame_pending=1 -> next cycle fb_wr_valid=0, no frame_done after release.
